// File: rtl/seg_link_pkg.sv
// Shared definitions for the 2-wire segment link (serial clock + serial data) to the 4-digit LED board.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents: frame geometry, transmitter FSM state enum, segment glyph constants, maxOf helper.
package seg_link_pkg;

  localparam int FRAME_BITS   = 10;  // addr[1:0] followed by data[7:0], MSB first
  localparam int FRAME_PULSES = 11;  // 10 data pulses plus the commit pulse
  localparam int ADDR_W       = 2;
  localparam int SEG_W        = 8;
  localparam int PULSE_W      = $clog2(FRAME_PULSES);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    GAP
  } txState_t;

  // Segment bit map: 0 right-high, 1 top, 2 left-high, 3 left-low,
  // 4 bottom, 5 right-low, 6 middle, 7 decimal point.
  localparam logic [SEG_W-1:0] SEG_0    = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 8'h21;
  localparam logic [SEG_W-1:0] SEG_2    = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 8'h73;
  localparam logic [SEG_W-1:0] SEG_4    = 8'h65;
  localparam logic [SEG_W-1:0] SEG_5    = 8'h76;
  localparam logic [SEG_W-1:0] SEG_6    = 8'h7E;
  localparam logic [SEG_W-1:0] SEG_7    = 8'h23;
  localparam logic [SEG_W-1:0] SEG_8    = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 8'h77;
  localparam logic [SEG_W-1:0] SEG_DASH = 8'h40;
  localparam logic [SEG_W-1:0] SEG_DP   = 8'h80;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_tx_phase_timer.sv
// Loadable down-counter timing the LOW, HIGH and GAP phases of the segment-link transmitter.
// Latency: load on edge K makes expired rise in the cycle that starts loadValue-1 edges later (phase lasts loadValue cycles).
// Backpressure: none; free-running once loaded, holds at zero.
// Ports: clock, reset (sync, active-high), load, loadValue[WIDTH] (phase length in cycles, >=1), expired (last cycle of phase).
module seg_tx_phase_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count holds the number of cycles left after the current one, so zero marks the final phase cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue - WIDTH'(1);
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/seg_serial_tx.sv
// Serialises {digit address, segment byte} frames onto the 2-wire segment link as 10 bit pulses plus 1 commit pulse.
// Latency: 22*HALF_PERIOD + GAP_CYCLES cycles from accept edge until frame_ready returns; frame_done on the last GAP cycle.
// Backpressure: frame_ready is high only in IDLE; frame_valid while busy is ignored (requester holds it).
// Ports: clock, reset (sync, active-high), frame_valid/frame_ready/frame_addr[2]/frame_data[8] (request handshake),
//        serial_clock_out, serial_data_out (link pins, straight from flops), busy, frame_done.
// Optional: define SERIAL_TX_MONITOR_EN to add monitor_led_n[2:0] (active-low: [0] commit HIGH, [1] ~clock, [2] ~data).
module seg_serial_tx
  import seg_link_pkg::*;
#(
  parameter int HALF_PERIOD = 262144,
  parameter int GAP_CYCLES  = 524288
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic [ADDR_W-1:0] frame_addr,
  input  logic [SEG_W-1:0]  frame_data,
  output logic              serial_clock_out,
  output logic              serial_data_out,
  output logic              busy,
  output logic              frame_done
`ifdef SERIAL_TX_MONITOR_EN
  ,
  output logic [2:0]        monitor_led_n
`endif
);

  localparam int TIMER_W = $clog2(maxOf(HALF_PERIOD, GAP_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(HALF_PERIOD);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES);
  localparam logic [PULSE_W-1:0] LAST_PULSE = PULSE_W'(FRAME_PULSES - 1);

  txState_t               state, stateNext;
  logic [PULSE_W-1:0]     pulseIdx, pulseNext;
  logic [FRAME_BITS-1:0]  shiftReg, shiftNext;
  logic                   clkReg, clkNext;
  logic                   dataReg, dataNext;
  logic                   timerLoad;
  logic [TIMER_W-1:0]     timerValue;
  logic                   timerExpired;

  seg_tx_phase_timer #(
    .WIDTH     (TIMER_W)
  ) phaseTimer (
    .clock     (clock),
    .reset     (reset),
    .load      (timerLoad),
    .loadValue (timerValue),
    .expired   (timerExpired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pulseIdx <= '0;
      shiftReg <= '0;
      clkReg   <= 1'b0;
      dataReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      pulseIdx <= pulseNext;
      shiftReg <= shiftNext;
      clkReg   <= clkNext;
      dataReg  <= dataNext;
    end
  end

  always_comb begin
    stateNext  = state;
    pulseNext  = pulseIdx;
    shiftNext  = shiftReg;
    clkNext    = clkReg;
    dataNext   = dataReg;
    timerLoad  = 1'b0;
    timerValue = HALF_LOAD;
    case (state)
      IDLE: begin
        clkNext  = 1'b0;
        dataNext = 1'b0;
        if (frame_valid) begin
          shiftNext = {frame_addr, frame_data};
          // Clock is already low, so the first bit can go out on the accept edge.
          dataNext  = frame_addr[ADDR_W-1];
          pulseNext = '0;
          timerLoad = 1'b1;
          stateNext = LOW;
        end
      end
      LOW: begin
        // Data follows the current bit throughout LOW. After a HIGH phase this
        // moves data one edge after the clock fall, so the two pins never
        // toggle on the same edge. The commit pulse sees an all-zero shifter.
        dataNext = shiftReg[FRAME_BITS-1];
        if (timerExpired) begin
          clkNext   = 1'b1;
          timerLoad = 1'b1;
          stateNext = HIGH;
        end
      end
      HIGH: begin
        if (timerExpired) begin
          clkNext   = 1'b0;
          timerLoad = 1'b1;
          if (pulseIdx == LAST_PULSE) begin
            timerValue = GAP_LOAD;
            stateNext  = GAP;
          end else begin
            pulseNext = pulseIdx + PULSE_W'(1);
            shiftNext = {shiftReg[FRAME_BITS-2:0], 1'b0};
            stateNext = LOW;
          end
        end
      end
      GAP: begin
        dataNext = 1'b0;
        if (timerExpired) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign serial_clock_out = clkReg;
  assign serial_data_out  = dataReg;
  assign frame_ready      = (state == IDLE);
  assign busy             = (state != IDLE);
  assign frame_done       = (state == GAP) && timerExpired;

`ifdef SERIAL_TX_MONITOR_EN
  assign monitor_led_n = {~dataReg, ~clkReg, ~((state == HIGH) && (pulseIdx == LAST_PULSE))};
`endif

endmodule
